// File: rtl/rom_arbiter_if.sv
// Bundle of the two requester ports and the ROM-side port of the ROM arbiter.
// The slave modport is the arbiter's view; the master modport is the view of
// the environment (requesters plus ROM) that drives the arbiter.
interface rom_arbiter_if;
  logic         req0_i;
  logic [31:0]  addr0_i;
  logic [127:0] data0_o;
  logic         ready0_o;
  logic         err0_o;

  logic         req1_i;
  logic [31:0]  addr1_i;
  logic [127:0] data1_o;
  logic         ready1_o;
  logic         err1_o;

  logic [31:0]  rom_addr_o;
  logic         rom_valid_o;
  logic [127:0] rom_data_i;
  logic         rom_ready_i;

  modport slave (
    input  req0_i, addr0_i, req1_i, addr1_i, rom_data_i, rom_ready_i,
    output data0_o, ready0_o, err0_o, data1_o, ready1_o, err1_o,
           rom_addr_o, rom_valid_o
  );

  modport master (
    output req0_i, addr0_i, req1_i, addr1_i, rom_data_i, rom_ready_i,
    input  data0_o, ready0_o, err0_o, data1_o, ready1_o, err1_o,
           rom_addr_o, rom_valid_o
  );
endinterface

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one 128-bit line-fetch ROM between the Icache
// refill port (0) and the Dcache/loader port (1). One ROM access at a time,
// line-aligned addressing, out-of-range rejection and a response timeout.
module rom_arbiter #(
  parameter int ROM_BYTES = 4096,
  parameter int TIMEOUT   = 15
) (
  input logic          clk,
  input logic          rst_n,
  rom_arbiter_if.slave bus
);

  localparam int             CW           = $clog2(TIMEOUT + 1);
  localparam logic [31:0]    ROM_LIMIT    = 32'(ROM_BYTES);
  localparam logic [CW-1:0]  TIMEOUT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic          lastGrant_q, lastGrant_d;
  logic          grant_q, grant_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   romAddr_q, romAddr_d;
  logic          romValid_q, romValid_d;
  logic [127:0]  data0_q, data0_d;
  logic          ready0_q, ready0_d;
  logic          err0_q, err0_d;
  logic [127:0]  data1_q, data1_d;
  logic          ready1_q, ready1_d;
  logic          err1_q, err1_d;

  logic          winner;
  logic [31:0]   lineAddr;

  // Pick the port to serve: a lone request wins, a tie goes to the port not granted last time.
  always_comb begin
    winner = bus.req1_i;
    if (bus.req0_i && bus.req1_i) begin
      winner = ~lastGrant_q;
    end
    lineAddr = (winner ? bus.addr1_i : bus.addr0_i) & 32'hFFFF_FFF0;
  end

  // Next-state and registered-output logic of the access sequencer.
  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    grant_d     = grant_q;
    count_d     = count_q;
    romAddr_d   = romAddr_q;
    romValid_d  = romValid_q;
    data0_d     = data0_q;
    ready0_d    = ready0_q;
    err0_d      = err0_q;
    data1_d     = data1_q;
    ready1_d    = ready1_q;
    err1_d      = err1_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req0_i || bus.req1_i) begin
          lastGrant_d = winner;
          grant_d     = winner;
          if (lineAddr < ROM_LIMIT) begin
            romValid_d = 1'b1;
            romAddr_d  = lineAddr;
            state_d    = S_REQ;
          end else if (winner) begin
            ready1_d = 1'b1;
            err1_d   = 1'b1;
            data1_d  = '0;
            state_d  = S_RESP;
          end else begin
            ready0_d = 1'b1;
            err0_d   = 1'b1;
            data0_d  = '0;
            state_d  = S_RESP;
          end
        end
      end

      S_REQ: begin
        romValid_d = 1'b0;
        count_d    = '0;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        if (bus.rom_ready_i) begin
          if (grant_q) begin
            data1_d  = bus.rom_data_i;
            ready1_d = 1'b1;
            err1_d   = 1'b0;
          end else begin
            data0_d  = bus.rom_data_i;
            ready0_d = 1'b1;
            err0_d   = 1'b0;
          end
          state_d = S_RESP;
        end else if (count_q == TIMEOUT_LAST) begin
          if (grant_q) begin
            data1_d  = '0;
            ready1_d = 1'b1;
            err1_d   = 1'b1;
          end else begin
            data0_d  = '0;
            ready0_d = 1'b1;
            err0_d   = 1'b1;
          end
          state_d = S_RESP;
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      S_RESP: begin
        data0_d  = '0;
        ready0_d = 1'b0;
        err0_d   = 1'b0;
        data1_d  = '0;
        ready1_d = 1'b0;
        err1_d   = 1'b0;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access and favours port 0 on the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lastGrant_q <= 1'b1;
      grant_q     <= 1'b0;
      count_q     <= '0;
      romAddr_q   <= '0;
      romValid_q  <= 1'b0;
      data0_q     <= '0;
      ready0_q    <= 1'b0;
      err0_q      <= 1'b0;
      data1_q     <= '0;
      ready1_q    <= 1'b0;
      err1_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      grant_q     <= grant_d;
      count_q     <= count_d;
      romAddr_q   <= romAddr_d;
      romValid_q  <= romValid_d;
      data0_q     <= data0_d;
      ready0_q    <= ready0_d;
      err0_q      <= err0_d;
      data1_q     <= data1_d;
      ready1_q    <= ready1_d;
      err1_q      <= err1_d;
    end
  end

  assign bus.data0_o     = data0_q;
  assign bus.ready0_o    = ready0_q;
  assign bus.err0_o      = err0_q;
  assign bus.data1_o     = data1_q;
  assign bus.ready1_o    = ready1_q;
  assign bus.err1_o      = err1_q;
  assign bus.rom_addr_o  = romAddr_q;
  assign bus.rom_valid_o = romValid_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Testbench for rom_arbiter: directed and randomized requests checked against a
// transaction-level model (round-robin winner, fixed latencies, ROM line contents).
module tb_rom_arbiter;

  localparam int ROM_BYTES = 4096;
  localparam int TIMEOUT   = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int total = 0;
  int bad   = 0;

  int          lastGrantModel = 1;
  logic        suppress       = 1'b0;
  logic        spurious       = 1'b0;
  logic        romPending     = 1'b0;
  logic [31:0] romPendAddr    = '0;
  logic [1:0]  pick;
  logic [31:0] a0, a1;

  rom_arbiter_if busIf();

  rom_arbiter #(
    .ROM_BYTES(ROM_BYTES),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (busIf)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Upper bound on run time so a stuck design cannot hang the bench.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [127:0] romLine(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, a * 32'd3, ~a, a + 32'h0101_0101};
  endfunction

  function automatic logic [31:0] randAddr();
    int sel;
    sel = $urandom_range(0, 5);
    if (sel == 0) return $urandom | 32'h0000_1000;
    if (sel == 1) return 32'h0000_1000 | 32'($urandom_range(0, 4095));
    return 32'($urandom_range(0, ROM_BYTES - 1));
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic [31:0] ad0,
                               input logic r1, input logic [31:0] ad1);
    busIf.req0_i  = r0;
    busIf.addr0_i = ad0;
    busIf.req1_i  = r1;
    busIf.addr1_i = ad1;
  endtask

  // ROM behaviour: answers one cycle after it samples rom_valid_o; otherwise
  // drives garbage data and, when asked, spurious ready strobes.
  task automatic romModel();
    if (romPending && !suppress) begin
      busIf.rom_ready_i = 1'b1;
      busIf.rom_data_i  = romLine(romPendAddr);
    end else begin
      busIf.rom_ready_i = spurious;
      busIf.rom_data_i  = {$urandom, $urandom, $urandom, $urandom};
    end
    romPending  = busIf.rom_valid_o;
    romPendAddr = busIf.rom_addr_o;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    romModel();
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_flags"},
                {124'b0, busIf.ready0_o, busIf.ready1_o, busIf.err0_o, busIf.err1_o}, '0);
    checkOutput({tag, "_data"}, busIf.data0_o | busIf.data1_o, '0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0);
    busIf.rom_ready_i = 1'b0;
    busIf.rom_data_i  = '0;
    romPending        = 1'b0;
    suppress          = 1'b0;
    spurious          = 1'b0;
    lastGrantModel    = 1;
    step();
    step();
    checkQuiet("reset");
    checkOutput("reset_valid", busIf.rom_valid_o, 1'b0);
    checkOutput("reset_addr", busIf.rom_addr_o, '0);
    rst_n = 1'b1;
    step();
  endtask

  // Serves one request from the current IDLE cycle and checks every cycle up to
  // the response pulse; the winner then drops its request and the bench moves
  // into the following IDLE cycle.
  task automatic serveOne(input string tag);
    int           w;
    int           lat;
    logic [31:0]  a;
    logic         inRange;
    logic [127:0] expData;
    logic         expErr;
    logic         readyW, errW, readyL, errL;
    logic [127:0] dataW, dataL;

    if (busIf.req0_i && busIf.req1_i) w = 1 - lastGrantModel;
    else if (busIf.req1_i)            w = 1;
    else                              w = 0;
    lastGrantModel = w;

    a       = (w == 1 ? busIf.addr1_i : busIf.addr0_i) & 32'hFFFF_FFF0;
    inRange = (a < 32'(ROM_BYTES));
    if (!inRange) begin
      lat = 1; expErr = 1'b1; expData = '0;
    end else if (suppress) begin
      lat = 2 + TIMEOUT; expErr = 1'b1; expData = '0;
    end else begin
      lat = 3; expErr = 1'b0; expData = romLine(a);
    end

    for (int k = 1; k <= lat; k++) begin
      step();
      checkOutput({tag, "_romvalid"}, busIf.rom_valid_o, (k == 1) && inRange);
      if (k == 1 && inRange) checkOutput({tag, "_romaddr"}, busIf.rom_addr_o, a);
      if (k < lat) begin
        checkQuiet({tag, "_busy"});
      end else begin
        readyW = (w == 1) ? busIf.ready1_o : busIf.ready0_o;
        errW   = (w == 1) ? busIf.err1_o   : busIf.err0_o;
        dataW  = (w == 1) ? busIf.data1_o  : busIf.data0_o;
        readyL = (w == 1) ? busIf.ready0_o : busIf.ready1_o;
        errL   = (w == 1) ? busIf.err0_o   : busIf.err1_o;
        dataL  = (w == 1) ? busIf.data0_o  : busIf.data1_o;
        checkOutput({tag, "_ready"}, readyW, 1'b1);
        checkOutput({tag, "_err"}, errW, expErr);
        checkOutput({tag, "_data"}, dataW, expData);
        checkOutput({tag, "_otherflags"}, {readyL, errL}, 2'b00);
        checkOutput({tag, "_otherdata"}, dataL, '0);
      end
    end

    if (w == 1) busIf.req1_i = 1'b0;
    else        busIf.req0_i = 1'b0;
    step();
    checkQuiet({tag, "_after"});
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin
    busIf.rom_ready_i = 1'b0;
    busIf.rom_data_i  = '0;
    applyStimulus(1'b0, '0, 1'b0, '0);

    $display("[TB] reset and single port-0 fetch");
    doReset();
    applyStimulus(1'b1, 32'h0000_0024, 1'b0, '0);
    serveOne("single0");

    $display("[TB] simultaneous requests alternate");
    doReset();
    applyStimulus(1'b1, 32'h0000_0010, 1'b1, 32'h0000_0040);
    serveOne("pairA_first");
    serveOne("pairA_second");
    applyStimulus(1'b1, 32'h0000_0080, 1'b0, '0);
    serveOne("lone0");
    applyStimulus(1'b1, 32'h0000_0050, 1'b1, 32'h0000_0060);
    serveOne("pairB_first");
    serveOne("pairB_second");

    $display("[TB] range boundary");
    applyStimulus(1'b0, '0, 1'b1, 32'h0000_1000);
    serveOne("oor1");
    applyStimulus(1'b1, 32'h0000_0FFF, 1'b0, '0);
    serveOne("lastline0");

    $display("[TB] ROM timeout then recovery");
    suppress = 1'b1;
    applyStimulus(1'b1, 32'h0000_0200, 1'b0, '0);
    serveOne("timeout0");
    suppress = 1'b0;
    applyStimulus(1'b1, 32'h0000_0210, 1'b0, '0);
    serveOne("recover0");

    $display("[TB] spurious ROM ready strobes");
    spurious = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checkQuiet("spur_idle");
      checkOutput("spur_idle_valid", busIf.rom_valid_o, 1'b0);
    end
    applyStimulus(1'b0, '0, 1'b1, 32'h0000_0334);
    serveOne("spur_txn");
    spurious = 1'b0;

    $display("[TB] randomized traffic");
    for (int i = 0; i < 10; i++) begin
      pick = 2'($urandom_range(1, 3));
      a0   = randAddr();
      a1   = randAddr();
      applyStimulus(pick[0], a0, pick[1], a1);
      serveOne("rnd_a");
      if (busIf.req0_i || busIf.req1_i) serveOne("rnd_b");
    end

    $display("[TB] reset during WAIT");
    suppress = 1'b1;
    applyStimulus(1'b1, 32'h0000_0100, 1'b0, '0);
    step();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checkQuiet("midreset");
    checkOutput("midreset_valid", busIf.rom_valid_o, 1'b0);
    checkOutput("midreset_addr", busIf.rom_addr_o, '0);
    romPending     = 1'b0;
    lastGrantModel = 1;
    applyStimulus(1'b0, '0, 1'b0, '0);
    step();
    checkQuiet("inreset");
    step();
    rst_n    = 1'b1;
    suppress = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checkQuiet("postreset");
    end
    applyStimulus(1'b1, 32'h0000_0300, 1'b1, 32'h0000_0400);
    serveOne("postreset_first");
    serveOne("postreset_second");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
